// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-road traffic light phase controller sequencing a shared beat timer
module traffic_phase_ctrl #(
  parameter logic [7:0] GREEN_BEATS  = 8'd12,
  parameter logic [7:0] YELLOW_BEATS = 8'd4,
  parameter logic [7:0] ALLRED_BEATS = 8'd2,
  parameter logic [7:0] WALK_BEATS   = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       walk_req,
  input  logic       timer_done,
  output logic [7:0] timer_load,
  output logic       timer_start,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G   = 3'd0,
    NS_Y   = 3'd1,
    RED_A  = 3'd2,
    WALK_A = 3'd3,
    EW_G   = 3'd4,
    EW_Y   = 3'd5,
    RED_B  = 3'd6,
    WALK_B = 3'd7
  } state_t;

  // A zero duration would leave the timer done immediately; clamp to one beat.
  localparam logic [7:0] G_DUR = (GREEN_BEATS  == 8'd0) ? 8'd1 : GREEN_BEATS;
  localparam logic [7:0] Y_DUR = (YELLOW_BEATS == 8'd0) ? 8'd1 : YELLOW_BEATS;
  localparam logic [7:0] R_DUR = (ALLRED_BEATS == 8'd0) ? 8'd1 : ALLRED_BEATS;
  localparam logic [7:0] W_DUR = (WALK_BEATS   == 8'd0) ? 8'd1 : WALK_BEATS;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  state_t     state;
  state_t     state_next;
  logic       walk_pending;
  logic       armed;
  logic       start_pending;
  logic       accept;
  logic       in_walk;
  logic [7:0] load_d;
  logic [2:0] ns_d;
  logic [2:0] ew_d;
  logic       walk_d;

  // Done is only trusted once the timer has seen our start, so a stale level cannot double-advance.
  assign accept  = armed & ~timer_start & timer_done;
  assign in_walk = (state == WALK_A) || (state == WALK_B) ||
                   (state_next == WALK_A) || (state_next == WALK_B);
  assign phase   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RED_B;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        NS_G:    state_next = NS_Y;
        NS_Y:    state_next = RED_A;
        RED_A:   state_next = walk_pending ? WALK_A : EW_G;
        WALK_A:  state_next = EW_G;
        EW_G:    state_next = EW_Y;
        EW_Y:    state_next = RED_B;
        RED_B:   state_next = walk_pending ? WALK_B : NS_G;
        WALK_B:  state_next = NS_G;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    ns_d   = LIGHT_RED;
    ew_d   = LIGHT_RED;
    walk_d = 1'b0;
    load_d = R_DUR;
    case (state_next)
      NS_G:           ns_d   = LIGHT_GRN;
      NS_Y:           ns_d   = LIGHT_YEL;
      EW_G:           ew_d   = LIGHT_GRN;
      EW_Y:           ew_d   = LIGHT_YEL;
      WALK_A, WALK_B: walk_d = 1'b1;
      default:        ;
    endcase
    case (state)
      NS_G, EW_G:     load_d = G_DUR;
      NS_Y, EW_Y:     load_d = Y_DUR;
      WALK_A, WALK_B: load_d = W_DUR;
      default:        load_d = R_DUR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_light      <= LIGHT_RED;
      ew_light      <= LIGHT_RED;
      walk          <= 1'b0;
      timer_start   <= 1'b0;
      timer_load    <= R_DUR;
      walk_pending  <= 1'b0;
      armed         <= 1'b0;
      start_pending <= 1'b1;
    end else begin
      ns_light     <= ns_d;
      ew_light     <= ew_d;
      walk         <= walk_d;
      walk_pending <= in_walk ? 1'b0 : (walk_pending | walk_req);
      if (start_pending) begin
        timer_start   <= 1'b1;
        timer_load    <= load_d;
        start_pending <= 1'b0;
        armed         <= 1'b0;
      end else begin
        timer_start <= 1'b0;
        if (accept) begin
          start_pending <= 1'b1;
          armed         <= 1'b0;
        end else if (timer_start) begin
          armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - scoreboard bench for traffic_phase_ctrl with a beat timer model
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2, walk_req, model_en;
  logic       timer_done, timer_start, walk;
  logic       timer_start2, walk2;
  logic [7:0] timer_load, timer_load2;
  logic [7:0] cnt = 8'd0;
  logic [2:0] ns_light, ew_light, phase, ns2, ew2, phase2;

  typedef struct packed {
    logic [2:0] ph;
    logic [7:0] ld;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
  } exp_t;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  exp_t q1[$];
  exp_t q2[$];
  int   tests = 0;
  int   fails = 0;
  int   starts1 = 0;
  int   starts2 = 0;

  traffic_phase_ctrl dut (
    .clk(clk), .rst(rst), .walk_req(walk_req), .timer_done(timer_done),
    .timer_load(timer_load), .timer_start(timer_start),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .phase(phase)
  );

  traffic_phase_ctrl #(.ALLRED_BEATS(8'd0)) dut_z (
    .clk(clk), .rst(rst2), .walk_req(1'b0), .timer_done(1'b1),
    .timer_load(timer_load2), .timer_start(timer_start2),
    .ns_light(ns2), .ew_light(ew2), .walk(walk2), .phase(phase2)
  );

  // Beat timer: loads on start, counts down to zero, reports done at zero.
  assign timer_done = model_en && (cnt == 8'd0);
  always @(posedge clk) begin
    if (timer_start) cnt <= timer_load;
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  end

  // Hand-written expected start record for each phase; red_ld is the red-phase load.
  function automatic exp_t e(input int ph, input logic [7:0] red_ld);
    case (ph)
      0:       e = {3'd0, 8'd12, G, R, 1'b0};
      1:       e = {3'd1, 8'd4,  Y, R, 1'b0};
      2:       e = {3'd2, red_ld, R, R, 1'b0};
      3:       e = {3'd3, 8'd8,  R, R, 1'b1};
      4:       e = {3'd4, 8'd12, R, G, 1'b0};
      5:       e = {3'd5, 8'd4,  R, Y, 1'b0};
      6:       e = {3'd6, red_ld, R, R, 1'b0};
      default: e = {3'd7, 8'd8,  R, R, 1'b1};
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_start(input string name, input exp_t x, input exp_t a);
    tests++;
    if (a != x) begin
      fails++;
      $display("FAIL %s: got phase=%0d load=%0d ns=%b ew=%b walk=%b, expected phase=%0d load=%0d ns=%b ew=%b walk=%b",
               name, a.ph, a.ld, a.ns, a.ew, a.wk, x.ph, x.ld, x.ns, x.ew, x.wk);
    end
  endtask

  task automatic mon1();
    forever begin
      @(negedge clk);
      if (!rst && timer_start) begin
        starts1++;
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dut unexpected start: got phase=%0d load=%0d, expected no start", phase, timer_load);
        end else begin
          check_start("dut start", q1.pop_front(), {phase, timer_load, ns_light, ew_light, walk});
        end
      end
    end
  endtask

  task automatic mon2();
    forever begin
      @(negedge clk);
      if (!rst2 && timer_start2) begin
        starts2++;
        if (q2.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dut_z unexpected start: got phase=%0d load=%0d, expected no start", phase2, timer_load2);
        end else begin
          check_start("dut_z start", q2.pop_front(), {phase2, timer_load2, ns2, ew2, walk2});
        end
      end
    end
  endtask

  task automatic wait1(input int n);
    int b = 0;
    while (starts1 < n && b < 1000) begin
      @(negedge clk);
      b++;
    end
    check("dut start count reached", int'(starts1 >= n), 1);
  endtask

  task automatic wait2(input int n);
    int b = 0;
    while (starts2 < n && b < 1000) begin
      @(negedge clk);
      b++;
    end
    check("dut_z start count reached", int'(starts2 >= n), 1);
  endtask

  task automatic pulse_walk();
    walk_req = 1'b1;
    @(negedge clk);
    walk_req = 1'b0;
  endtask

  int seq1[31] = '{6, 0, 1, 2, 4, 5, 6, 0,
                   1, 2, 3, 4, 5, 6, 0,
                   1, 2, 4, 5, 6, 7, 0, 1, 2, 4, 5,
                   6, 0, 1, 2, 4};
  int seq2[8]  = '{6, 0, 1, 2, 4, 5, 6, 0};

  initial begin
    int b;
    rst = 1'b1; rst2 = 1'b1; walk_req = 1'b0; model_en = 1'b0;
    fork
      mon1();
      mon2();
    join_none
    foreach (seq1[i]) q1.push_back(e(seq1[i], 8'd2));
    foreach (seq2[i]) q2.push_back(e(seq2[i], 8'd1));

    repeat (3) @(posedge clk);
    #1;
    check("reset phase", int'(phase), 6);
    check("reset ns_light", int'(ns_light), 4);
    check("reset ew_light", int'(ew_light), 4);
    check("reset walk", int'(walk), 0);
    check("reset timer_start", int'(timer_start), 0);
    check("reset timer_load", int'(timer_load), 2);
    check("reset timer_load zero allred", int'(timer_load2), 1);

    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    wait2(8);
    rst2 = 1'b1;
    check("single start while timer idle", starts1, 1);

    model_en = 1'b1;
    wait1(8);
    pulse_walk();

    wait1(18);
    pulse_walk();
    wait1(20);
    b = 0;
    while (!(phase == 3'd6 && timer_done && !timer_start) && b < 1000) begin
      @(negedge clk);
      b++;
    end
    check("red_b acceptance seen", int'(b < 1000), 1);
    walk_req = 1'b1;
    repeat (2) @(negedge clk);
    walk_req = 1'b0;

    wait1(25);
    pulse_walk();
    wait1(26);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset phase", int'(phase), 6);
    check("mid reset ns_light", int'(ns_light), 4);
    check("mid reset ew_light", int'(ew_light), 4);
    check("mid reset walk", int'(walk), 0);
    check("mid reset timer_start", int'(timer_start), 0);
    check("mid reset timer_load", int'(timer_load), 2);
    @(negedge clk);
    rst = 1'b0;

    wait1(31);
    repeat (5) @(negedge clk);
    check("dut expectations left", q1.size(), 0);
    check("dut_z expectations left", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
